// File: rtl/hdlverifier_capture_trigger_if.sv
// Trigger sequencer bus: sample qualifier, monitored signals,
// synchronized JTAG-side config, and the trigger/status outputs.
interface hdlverifier_capture_trigger_if #(
  parameter int TRIG_WIDTH = 8,
  parameter int NUM_STAGES = 2,
  parameter int CNT_WIDTH  = 8
);
  logic                                clk_enable;
  logic [TRIG_WIDTH-1:0]               trigger_signals;
  logic                                arm;
  logic [3*TRIG_WIDTH*NUM_STAGES-1:0]  trig_mode;
  logic [NUM_STAGES-1:0]               trig_comb;
  logic [CNT_WIDTH*NUM_STAGES-1:0]     trig_count;
  logic                                trigger;
  logic                                armed;
  logic [1:0]                          stage;

  modport master (
    output clk_enable,
    output trigger_signals,
    output arm,
    output trig_mode,
    output trig_comb,
    output trig_count,
    input  trigger,
    input  armed,
    input  stage
  );

  modport slave (
    input  clk_enable,
    input  trigger_signals,
    input  arm,
    input  trig_mode,
    input  trig_comb,
    input  trig_count,
    output trigger,
    output armed,
    output stage
  );
endinterface

// File: rtl/hdlverifier_capture_trigger.sv
// Multi-stage level/edge trigger sequencer feeding the capture
// buffer's trigger input with a one-cycle registered pulse.
module hdlverifier_capture_trigger #(
  parameter int TRIG_WIDTH = 8,
  parameter int NUM_STAGES = 2,
  parameter int CNT_WIDTH  = 8
) (
  input logic clk,
  input logic reset_n,
  hdlverifier_capture_trigger_if.slave bus
);

  localparam int MW = 3 * TRIG_WIDTH * NUM_STAGES;
  localparam int CW = CNT_WIDTH * NUM_STAGES;
  localparam logic [1:0] LAST = 2'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_t;

  state_t                 state;
  logic                   arm_d1;
  logic                   trigger_q;
  logic                   armed_q;
  logic [1:0]             stage_q;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [TRIG_WIDTH-1:0]  prev;
  logic                   prev_valid;
  logic [MW-1:0]          sh_mode;
  logic [NUM_STAGES-1:0]  sh_comb;
  logic [CW-1:0]          sh_count;

  logic                   cond;
  logic                   all_ok;
  logic                   any_ok;
  logic [CNT_WIDTH-1:0]   target;
  logic                   comb_or;

  // Evaluate only the stage currently being sequenced.
  always_comb begin
    logic [2:0] m;
    logic       cur;
    logic       p;
    logic       t;
    logic       act;
    all_ok  = 1'b1;
    any_ok  = 1'b0;
    m       = 3'd0;
    cur     = 1'b0;
    p       = 1'b0;
    t       = 1'b0;
    act     = 1'b0;
    for (int b = 0; b < TRIG_WIDTH; b++) begin
      m   = sh_mode[3*(int'(stage_q)*TRIG_WIDTH+b) +: 3];
      cur = bus.trigger_signals[b];
      p   = prev[b];
      act = 1'b1;
      case (m)
        3'd1:    t = !cur;
        3'd2:    t = cur;
        3'd3:    t = prev_valid && !p && cur;
        3'd4:    t = prev_valid && p && !cur;
        3'd5:    t = prev_valid && (p ^ cur);
        default: begin
          t   = 1'b0;
          act = 1'b0;
        end
      endcase
      if (act) begin
        all_ok = all_ok & t;
        any_ok = any_ok | t;
      end
    end
    comb_or = sh_comb[stage_q];
    cond    = comb_or ? any_ok : all_ok;
    target  = sh_count[int'(stage_q)*CNT_WIDTH +: CNT_WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      arm_d1     <= 1'b0;
      trigger_q  <= 1'b0;
      armed_q    <= 1'b0;
      stage_q    <= 2'd0;
      cnt        <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      sh_mode    <= '0;
      sh_comb    <= '0;
      sh_count   <= '0;
    end else begin
      arm_d1    <= bus.arm;
      trigger_q <= 1'b0;
      if (!bus.arm) begin
        state   <= IDLE;
        armed_q <= 1'b0;
        stage_q <= 2'd0;
        cnt     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!arm_d1) begin
              state      <= ARMED;
              armed_q    <= 1'b1;
              stage_q    <= 2'd0;
              cnt        <= '0;
              prev_valid <= 1'b0;
              sh_mode    <= bus.trig_mode;
              sh_comb    <= bus.trig_comb;
              sh_count   <= bus.trig_count;
            end
          end
          ARMED: begin
            if (bus.clk_enable) begin
              prev       <= bus.trigger_signals;
              prev_valid <= 1'b1;
              if (cond) begin
                if (cnt == target) begin
                  cnt <= '0;
                  if (stage_q == LAST) begin
                    state     <= FIRED;
                    trigger_q <= 1'b1;
                    armed_q   <= 1'b0;
                    stage_q   <= 2'd0;
                  end else begin
                    stage_q <= stage_q + 2'd1;
                  end
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end
            end
          end
          FIRED: begin
            armed_q <= 1'b0;
            stage_q <= 2'd0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.trigger = trigger_q;
  assign bus.armed   = armed_q;
  assign bus.stage   = stage_q;

endmodule

// File: tb/tb_hdlverifier_capture_trigger.sv
// Directed bench: one-stage and two-stage sequencers sharing
// clock and reset, checked against hand-derived expectations.
module tb_hdlverifier_capture_trigger;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  hdlverifier_capture_trigger_if #(8, 1, 8) i1 ();
  hdlverifier_capture_trigger_if #(8, 2, 8) i2 ();

  hdlverifier_capture_trigger #(
    .TRIG_WIDTH(8), .NUM_STAGES(1), .CNT_WIDTH(8)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(i1.slave)
  );

  hdlverifier_capture_trigger #(
    .TRIG_WIDTH(8), .NUM_STAGES(2), .CNT_WIDTH(8)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(i2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm1();
    i1.arm = 1'b0;
    tick();
    i1.arm = 1'b1;
    tick();
  endtask

  task automatic arm2();
    i2.arm = 1'b0;
    tick();
    i2.arm = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i1.clk_enable = 0; i1.trigger_signals = 0; i1.arm = 0;
    i1.trig_mode = 0; i1.trig_comb = 0; i1.trig_count = 0;
    i2.clk_enable = 0; i2.trigger_signals = 0; i2.arm = 0;
    i2.trig_mode = 0; i2.trig_comb = 0; i2.trig_count = 0;
    tick();
    tick();
    tests++;
    if ({i1.trigger, i1.armed, i1.stage} !== 4'b0) begin
      fails++;
      $display("FAIL reset1 got %b exp 0000",
               {i1.trigger, i1.armed, i1.stage});
    end
    tests++;
    if ({i2.trigger, i2.armed, i2.stage} !== 4'b0) begin
      fails++;
      $display("FAIL reset2 got %b exp 0000",
               {i2.trigger, i2.armed, i2.stage});
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_level_single();
    int pulses;
    i1.trig_mode = 24'h000002;
    i1.trig_comb = 1'b0;
    i1.trig_count = 8'd0;
    i1.clk_enable = 1'b1;
    i1.trigger_signals = 8'h00;
    arm1();
    tests++;
    if (i1.armed !== 1'b1 || i1.trigger !== 1'b0) begin
      fails++;
      $display("FAIL lvl_armed got armed=%b trig=%b exp 1 0",
               i1.armed, i1.trigger);
    end
    i1.trigger_signals = 8'h01;
    tick();
    tests++;
    if (i1.trigger !== 1'b1 || i1.armed !== 1'b0) begin
      fails++;
      $display("FAIL lvl_pulse got trig=%b armed=%b exp 1 0",
               i1.trigger, i1.armed);
    end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (i1.trigger === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0 || i1.armed !== 1'b0) begin
      fails++;
      $display("FAIL lvl_fired got pulses=%0d armed=%b exp 0 0",
               pulses, i1.armed);
    end
    i1.arm = 1'b0;
    tick();
  endtask

  task automatic test_rising_count();
    logic [7:0] sig [12];
    logic       ce  [12];
    logic       ex  [12];
    sig = '{8'h08, 8'h00, 8'h08, 8'h08, 8'h08, 8'h00,
            8'h00, 8'h08, 8'h00, 8'h08, 8'h08, 8'h00};
    ce  = '{1, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1};
    ex  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    i1.trig_mode = 24'd3 << 9;
    i1.trig_comb = 1'b0;
    i1.trig_count = 8'd2;
    i1.clk_enable = 1'b1;
    i1.trigger_signals = 8'h08;
    arm1();
    for (int k = 0; k < 12; k++) begin
      i1.clk_enable = ce[k];
      i1.trigger_signals = sig[k];
      tick();
      tests++;
      if (i1.trigger !== ex[k]) begin
        fails++;
        $display("FAIL rise_step%0d got %b exp %b",
                 k, i1.trigger, ex[k]);
      end
    end
    i1.arm = 1'b0;
    tick();
  endtask

  task automatic test_two_stage();
    i2.trig_mode = (48'd4 << 45) | 48'h12;
    i2.trig_comb = 2'b01;
    i2.trig_count = 16'h0000;
    i2.clk_enable = 1'b1;
    i2.trigger_signals = 8'h80;
    arm2();
    tick();
    tests++;
    if (i2.stage !== 2'd0 || i2.trigger !== 1'b0) begin
      fails++;
      $display("FAIL two_idle got stage=%0d trig=%b exp 0 0",
               i2.stage, i2.trigger);
    end
    i2.trigger_signals = 8'h01;
    tick();
    tests++;
    if (i2.stage !== 2'd1 || i2.trigger !== 1'b0) begin
      fails++;
      $display("FAIL two_adv got stage=%0d trig=%b exp 1 0",
               i2.stage, i2.trigger);
    end
    i2.trigger_signals = 8'h00;
    tick();
    i2.trigger_signals = 8'h80;
    tick();
    tests++;
    if (i2.stage !== 2'd1 || i2.trigger !== 1'b0) begin
      fails++;
      $display("FAIL two_hold got stage=%0d trig=%b exp 1 0",
               i2.stage, i2.trigger);
    end
    i2.trigger_signals = 8'h00;
    tick();
    tests++;
    if (i2.stage !== 2'd0 || i2.trigger !== 1'b1) begin
      fails++;
      $display("FAIL two_fire got stage=%0d trig=%b exp 0 1",
               i2.stage, i2.trigger);
    end
    i2.arm = 1'b0;
    tick();
  endtask

  task automatic test_dont_care();
    int pulses;
    i1.trig_mode = 24'h0;
    i1.trig_comb = 1'b0;
    i1.trig_count = 8'd0;
    i1.clk_enable = 1'b1;
    i1.trigger_signals = 8'h5a;
    arm1();
    tick();
    tests++;
    if (i1.trigger !== 1'b1) begin
      fails++;
      $display("FAIL dc_and got %b exp 1", i1.trigger);
    end
    i1.arm = 1'b0;
    tick();
    i1.trig_comb = 1'b1;
    arm1();
    pulses = 0;
    for (int k = 0; k < 1000; k++) begin
      i1.trigger_signals = 8'($urandom);
      tick();
      if (i1.trigger === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0 || i1.armed !== 1'b1) begin
      fails++;
      $display("FAIL dc_or got pulses=%0d armed=%b exp 0 1",
               pulses, i1.armed);
    end
    i1.arm = 1'b0;
    tick();
  endtask

  task automatic test_disarm_shadow();
    logic ex [4];
    ex = '{0, 0, 0, 1};
    i2.trig_mode = (48'd2 << 27) | 48'd2;
    i2.trig_comb = 2'b00;
    i2.trig_count = 16'h0300;
    i2.clk_enable = 1'b1;
    i2.trigger_signals = 8'h00;
    arm2();
    i2.trigger_signals = 8'h01;
    tick();
    i2.trigger_signals = 8'h02;
    tick();
    tick();
    tests++;
    if (i2.stage !== 2'd1 || i2.armed !== 1'b1) begin
      fails++;
      $display("FAIL dis_mid got stage=%0d armed=%b exp 1 1",
               i2.stage, i2.armed);
    end
    i2.arm = 1'b0;
    tick();
    tests++;
    if (i2.armed !== 1'b0 || i2.stage !== 2'd0) begin
      fails++;
      $display("FAIL dis_idle got armed=%b stage=%0d exp 0 0",
               i2.armed, i2.stage);
    end
    i2.trigger_signals = 8'h00;
    arm2();
    i2.trig_count = 16'h0000;
    i2.trigger_signals = 8'h01;
    tick();
    i2.trigger_signals = 8'h02;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (i2.trigger !== ex[k]) begin
        fails++;
        $display("FAIL shadow_step%0d got %b exp %b",
                 k, i2.trigger, ex[k]);
      end
    end
    i2.arm = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    i2.trig_mode = 48'd2;
    i2.trig_comb = 2'b00;
    i2.trig_count = 16'h0005;
    i2.clk_enable = 1'b1;
    i2.trigger_signals = 8'h01;
    arm2();
    tick();
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({i2.trigger, i2.armed, i2.stage} !== 4'b0) begin
      fails++;
      $display("FAIL arst_now got %b exp 0000",
               {i2.trigger, i2.armed, i2.stage});
    end
    i2.trig_count = 16'h0000;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tests++;
    if (i2.armed !== 1'b1) begin
      fails++;
      $display("FAIL arst_rearm got %b exp 1", i2.armed);
    end
    tick();
    tests++;
    if (i2.stage !== 2'd1 || i2.trigger !== 1'b0) begin
      fails++;
      $display("FAIL arst_cfg got stage=%0d trig=%b exp 1 0",
               i2.stage, i2.trigger);
    end
    tick();
    tests++;
    if (i2.trigger !== 1'b1) begin
      fails++;
      $display("FAIL arst_fire got %b exp 1", i2.trigger);
    end
    i2.arm = 1'b0;
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_level_single();
    test_rising_count();
    test_two_stage();
    test_dont_care();
    test_disarm_shadow();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
